// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with a registered ID/EX output slot.
//
// One instruction is offered per cycle from fetch (in_valid/in_ready). The
// stage drives register-file read addresses combinationally from in_inst,
// selects operands (optionally forwarding the writeback port), builds the
// sign-extended immediate, flags illegal encodings and registers the result
// into a single output slot (out_valid/out_ready). While the slot is stalled,
// writebacks to the held source registers refresh the held operands.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      fetch handshake; in_inst, in_pc offered word/address
//   rs1_addr, rs2_addr     register-file read addresses (combinational)
//   rs1_rdata, rs2_rdata   register-file read data (same cycle)
//   wb_wen/wb_addr/wb_data writeback port, observed for forwarding
//   flush                  drop held and offered instruction
//   out_valid/out_ready    execute handshake
//   out_*                  decoded fields of the held instruction

// Per-source operand select: x0 reads zero, then forwarded writeback, then rdata.
module operand_sel #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rdata,
  input  logic            wb_wen,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data
);
  always_comb begin
    if (addr == 5'd0)                                  data = '0;
    else if (BYPASS_EN && wb_wen && (wb_addr == addr)) data = wb_data;
    else                                               data = rdata;
  end
endmodule

module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            wb_wen,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic            out_illegal
);
  localparam int NSRC = 2;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // ---------------- combinational decode ----------------
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic is_opimm, is_op, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic legal, rs1_used, rs2_used, rd_used;
  logic [31:0] imm32;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd     = in_inst[11:7];

  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  assign rs1_used = is_opimm | is_op | is_branch | is_jalr;
  assign rs2_used = is_op | is_branch;
  assign rd_used  = is_opimm | is_op | is_jal | is_jalr | is_lui | is_auipc;

  always_comb begin
    legal = 1'b0;
    if (is_opimm) begin
      // Shift immediates reuse funct7 as an encoding field.
      if (funct3 == 3'b001)      legal = (funct7 == F7_ZERO);
      else if (funct3 == 3'b101) legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      else                       legal = 1'b1;
    end else if (is_op) begin
      legal = (funct7 == F7_ZERO) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_branch) begin
      legal = (funct3 != 3'b010) && (funct3 != 3'b011);
    end else if (is_jalr) begin
      legal = (funct3 == 3'b000);
    end else if (is_jal || is_lui || is_auipc) begin
      legal = 1'b1;
    end
  end

  // Immediate built at 32 bits; bit 31 is always the sign for the later widening.
  always_comb begin
    imm32 = '0;
    if (is_opimm && ((funct3 == 3'b001) || (funct3 == 3'b101)))
      imm32 = {27'd0, in_inst[24:20]};
    else if (is_opimm || is_jalr)
      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    else if (is_branch)
      imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_jal)
      imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    else if (is_lui || is_auipc)
      imm32 = {in_inst[31:12], 12'd0};
  end

  assign rs1_addr = rs1_used ? in_inst[19:15] : 5'd0;
  assign rs2_addr = rs2_used ? in_inst[24:20] : 5'd0;

  // ---------------- operand select ----------------
  logic [NSRC-1:0][4:0]      src_addr;
  logic [NSRC-1:0][XLEN-1:0] src_rdata, src_data;

  assign src_addr  = {rs2_addr, rs1_addr};
  assign src_rdata = {rs2_rdata, rs1_rdata};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    operand_sel #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_sel (
      .addr    (src_addr[s]),
      .rdata   (src_rdata[s]),
      .wb_wen  (wb_wen),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data    (src_data[s])
    );
  end

  // ---------------- handshake ----------------
  logic capture, stall;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready;
  assign stall    = out_valid && !out_ready;

  // ---------------- output slot ----------------
  logic [NSRC-1:0][4:0]      held_addr;
  logic [NSRC-1:0][XLEN-1:0] held_data;

  assign out_rs1_data = held_data[0];
  assign out_rs2_data = held_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_imm     <= '0;
      out_rd_addr <= '0;
      out_rd_wen  <= 1'b0;
      out_illegal <= 1'b0;
      held_addr   <= '0;
      held_data   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opcode;
      out_illegal <= !legal;
      if (legal) begin
        out_funct3  <= funct3;
        out_funct7  <= funct7;
        out_imm     <= XLEN'($signed(imm32));
        out_rd_addr <= rd_used ? rd : 5'd0;
        out_rd_wen  <= rd_used && (rd != 5'd0);
        held_addr   <= src_addr;
        held_data   <= src_data;
      end else begin
        // Zeroed held addresses also keep an illegal slot out of refresh.
        out_funct3  <= '0;
        out_funct7  <= '0;
        out_imm     <= '0;
        out_rd_addr <= '0;
        out_rd_wen  <= 1'b0;
        held_addr   <= '0;
        held_data   <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (stall && BYPASS_EN) begin
      // Held operands track writebacks so execute never sees stale data.
      for (int s = 0; s < NSRC; s++) begin
        if (wb_wen && (held_addr[s] != 5'd0) && (wb_addr == held_addr[s]))
          held_data[s] <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. A second instance with forwarding disabled
// shares all inputs so the no-bypass result can be compared side by side.
module tb_decode_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, flush, out_ready, wb_wen;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, rs1_rdata, rs2_rdata, wb_data;
  logic [4:0]      wb_addr;

  logic            in_ready, out_valid, out_rd_wen, out_illegal;
  logic [4:0]      rs1_addr, rs2_addr, out_rd_addr;
  logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;

  logic            nb_in_ready, nb_out_valid, nb_out_rd_wen, nb_out_illegal;
  logic [4:0]      nb_rs1_addr, nb_rs2_addr, nb_out_rd_addr;
  logic [XLEN-1:0] nb_out_pc, nb_out_rs1_data, nb_out_rs2_data, nb_out_imm;
  logic [6:0]      nb_out_opcode, nb_out_funct7;
  logic [2:0]      nb_out_funct3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .wb_wen(wb_wen),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd_addr(out_rd_addr),
    .out_rd_wen(out_rd_wen), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(XLEN), .BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nb_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(nb_rs1_addr), .rs2_addr(nb_rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .wb_wen(wb_wen),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_valid(nb_out_valid),
    .out_ready(out_ready), .out_pc(nb_out_pc), .out_opcode(nb_out_opcode),
    .out_funct3(nb_out_funct3), .out_funct7(nb_out_funct7),
    .out_rs1_data(nb_out_rs1_data), .out_rs2_data(nb_out_rs2_data),
    .out_imm(nb_out_imm), .out_rd_addr(nb_out_rd_addr),
    .out_rd_wen(nb_out_rd_wen), .out_illegal(nb_out_illegal)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_wen = 1'b0;
    in_inst = 32'h0; in_pc = '0; rs1_rdata = '0; rs2_rdata = '0; wb_data = '0; wb_addr = '0;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %h want 0", out_valid); end
    vectors++; if (out_imm !== 32'h0) begin miscompares++; $display("FAIL reset_imm got %h want 0", out_imm); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %h want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_inst = 32'hFFD08293; in_pc = 32'h100; rs1_rdata = 32'd10; out_ready = 1'b1;
    #1;
    vectors++; if (rs1_addr !== 5'd1) begin miscompares++; $display("FAIL addi_rs1_addr got %0d want 1", rs1_addr); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %h want 1", out_valid); end
    vectors++; if (out_rs1_data !== 32'd10) begin miscompares++; $display("FAIL addi_rs1 got %h want a", out_rs1_data); end
    vectors++; if (out_imm !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL addi_imm got %h want fffffffd", out_imm); end
    vectors++; if (out_rd_addr !== 5'd5 || out_rd_wen !== 1'b1 || out_illegal !== 1'b0)
      begin miscompares++; $display("FAIL addi_rd got rd=%0d wen=%h ill=%h want 5/1/0", out_rd_addr, out_rd_wen, out_illegal); end
    vectors++; if (out_pc !== 32'h100) begin miscompares++; $display("FAIL addi_pc got %h want 100", out_pc); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got %h want 0", out_valid); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_inst = 32'hFE208CE3; in_pc = 32'h200; rs1_rdata = 32'd3; rs2_rdata = 32'd4;
    step();
    vectors++; if (out_imm !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL beq_imm got %h want fffffff8", out_imm); end
    vectors++; if (out_rd_wen !== 1'b0 || out_rd_addr !== 5'd0 || out_illegal !== 1'b0)
      begin miscompares++; $display("FAIL beq_rd got wen=%h rd=%0d ill=%h want 0/0/0", out_rd_wen, out_rd_addr, out_illegal); end
    vectors++; if (out_rs2_data !== 32'd4) begin miscompares++; $display("FAIL beq_rs2 got %h want 4", out_rs2_data); end
    in_inst = 32'hFE20ACE3; in_pc = 32'h204;
    step();
    in_valid = 1'b0;
    vectors++; if (out_illegal !== 1'b1 || out_rd_wen !== 1'b0 || out_imm !== 32'h0 || out_rs1_data !== 32'h0)
      begin miscompares++; $display("FAIL bill got ill=%h wen=%h imm=%h rs1=%h want 1/0/0/0", out_illegal, out_rd_wen, out_imm, out_rs1_data); end
    vectors++; if (out_opcode !== 7'h63 || out_pc !== 32'h204)
      begin miscompares++; $display("FAIL bill_pass got op=%h pc=%h want 63/204", out_opcode, out_pc); end
    step();
  endtask

  task automatic test_decode_table();
    logic [31:0] insts [6] = '{32'h4040D493, 32'h02009093, 32'h008000EF, 32'hFFFFF517, 32'h000080E7, 32'h000090E7};
    logic [31:0] imms  [6] = '{32'h4,        32'h0,        32'h8,        32'hFFFFF000, 32'h0,        32'h0};
    logic        ills  [6] = '{1'b0,         1'b1,         1'b0,         1'b0,         1'b0,         1'b1};
    logic        wens  [6] = '{1'b1,         1'b0,         1'b1,         1'b1,         1'b1,         1'b0};
    rs1_rdata = 32'h11; rs2_rdata = 32'h22; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_inst = insts[i];
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_imm !== imms[i] || out_illegal !== ills[i] || out_rd_wen !== wens[i]) begin
        miscompares++;
        $display("FAIL table[%0d] got v=%h imm=%h ill=%h wen=%h want 1/%h/%h/%h",
                 i, out_valid, out_imm, out_illegal, out_rd_wen, imms[i], ills[i], wens[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h300;
    rs1_rdata = 32'h11; rs2_rdata = 32'h22; out_ready = 1'b0;
    step();
    in_inst = 32'h00500313; in_pc = 32'h304; rs1_rdata = 32'hBAD1; rs2_rdata = 32'hBAD2;
    for (int c = 1; c <= 3; c++) begin
      wb_wen = (c == 2); wb_addr = 5'd2; wb_data = 32'h55;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got %h want 0", c, in_ready); end
      step();
      wb_wen = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_rs1_data !== 32'h11 || out_rs2_data !== ((c >= 2) ? 32'h55 : 32'h22) ||
          out_rd_addr !== 5'd3 || out_pc !== 32'h300 || out_opcode !== 7'h33) begin
        miscompares++;
        $display("FAIL stall[%0d] got v=%h rs1=%h rs2=%h rd=%0d pc=%h", c, out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_rd_addr !== 5'd6 || out_imm !== 32'h5 || out_rs1_data !== 32'h0 || out_pc !== 32'h304)
      begin miscompares++; $display("FAIL b2b got v=%h rd=%0d imm=%h rs1=%h pc=%h", out_valid, out_rd_addr, out_imm, out_rs1_data, out_pc); end
    step();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_inst = 32'h40208233; out_ready = 1'b1;
    wb_wen = 1'b1; wb_addr = 5'd1; wb_data = 32'h7; rs1_rdata = 32'h2; rs2_rdata = 32'h9;
    step();
    vectors++; if (out_rs1_data !== 32'h7) begin miscompares++; $display("FAIL bypass_rs1 got %h want 7", out_rs1_data); end
    vectors++; if (nb_out_rs1_data !== 32'h2) begin miscompares++; $display("FAIL nobypass_rs1 got %h want 2", nb_out_rs1_data); end
    vectors++; if (out_rs2_data !== 32'h9 || out_funct7 !== 7'h20 || out_illegal !== 1'b0)
      begin miscompares++; $display("FAIL sub_fields got rs2=%h f7=%h ill=%h want 9/20/0", out_rs2_data, out_funct7, out_illegal); end
    in_inst = 32'h00100413; wb_addr = 5'd0; wb_data = 32'hDEAD; rs1_rdata = 32'h1234;
    step();
    in_valid = 1'b0; wb_wen = 1'b0;
    vectors++; if (out_rs1_data !== 32'h0 || out_imm !== 32'h1 || out_rd_addr !== 5'd8)
      begin miscompares++; $display("FAIL x0_read got rs1=%h imm=%h rd=%0d want 0/1/8", out_rs1_data, out_imm, out_rd_addr); end
    step();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_inst = 32'h002081B3; out_ready = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre got %h want 1", out_valid); end
    flush = 1'b1; in_inst = 32'h123453B7;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %h want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %h want 0", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got %h want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h500;
    rs1_rdata = 32'h11; rs2_rdata = 32'h22; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b1 || out_rd_wen !== 1'b1) begin miscompares++; $display("FAIL pre_rst got v=%h wen=%h want 1/1", out_valid, out_rd_wen); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_rd_wen !== 1'b0 || out_pc !== 32'h0 || out_imm !== 32'h0 ||
        out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0 || out_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got v=%h wen=%h pc=%h rs1=%h rs2=%h", out_valid, out_rd_wen, out_pc, out_rs1_data, out_rs2_data);
    end
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_inst = 32'h123453B7; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_rd_addr !== 5'd7 || out_rd_wen !== 1'b1)
      begin miscompares++; $display("FAIL lui got v=%h imm=%h rd=%0d wen=%h want 1/12345000/7/1", out_valid, out_imm, out_rd_addr, out_rd_wen); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_decode_table();
    test_stall();
    test_bypass();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
